// File: rtl/pipe_alu.sv
// Two-stage valid/ready ALU: and/or/add/sub/slt with carry, overflow and zero flags.
// Latency 2 cycles; full throughput; in_ready = !v1 || stage 2 loads (combinational on out_ready).
// Backpressure stalls both stages in place; `PIPE_ALU_STICKY_OVF_EN adds a sticky overflow flag.
module pipe_alu #(
    parameter int N = 32,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [M-1:0] f,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         overflow,
`ifdef PIPE_ALU_STICKY_OVF_EN
    output logic         zero,
    output logic         sticky_ovf,
    input  logic         clr_sticky
`else
    output logic         zero
`endif
);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [M-1:0] f;
    } op_t;

    typedef struct packed {
        logic [N-1:0] y;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    localparam logic [M-1:0] F_AND  = 3'b000;
    localparam logic [M-1:0] F_OR   = 3'b001;
    localparam logic [M-1:0] F_ADD  = 3'b010;
    localparam logic [M-1:0] F_ANDN = 3'b100;
    localparam logic [M-1:0] F_ORN  = 3'b101;
    localparam logic [M-1:0] F_SUB  = 3'b110;
    localparam logic [M-1:0] F_SLT  = 3'b111;

    op_t  op_q;
    logic v1;
    res_t res_q;
    logic v2;

    logic load1;
    logic load2;
    logic retire;

    assign retire   = v2 && out_ready;
    assign load2    = !v2 || out_ready;
    assign in_ready = !v1 || load2;
    assign load1    = in_valid && in_ready;

    // Stage 1: operand capture. Operands are only sampled on an accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
        end else if (in_ready) begin
            v1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load1) begin
            op_q <= '{a: a, b: b, f: f};
        end
    end

    // Shared adder: a + (f[2] ? ~b : b) + f[2], one bit wider for the carry.
    logic [N-1:0] bb;
    logic [N:0]   sum;
    logic         arith;
    logic         ovf_raw;
    res_t         res_c;

    always_comb begin
        bb      = op_q.f[2] ? ~op_q.b : op_q.b;
        sum     = {1'b0, op_q.a} + {1'b0, bb} + {{N{1'b0}}, op_q.f[2]};
        arith   = (op_q.f == F_ADD) || (op_q.f == F_SUB) || (op_q.f == F_SLT);
        ovf_raw = (op_q.a[N-1] == bb[N-1]) && (sum[N-1] != op_q.a[N-1]);
    end

    always_comb begin
        res_c = '0;
        unique case (op_q.f)
            F_AND:  res_c.y = op_q.a & op_q.b;
            F_OR:   res_c.y = op_q.a | op_q.b;
            F_ANDN: res_c.y = op_q.a & bb;
            F_ORN:  res_c.y = op_q.a | bb;
            F_ADD,
            F_SUB:  res_c.y = sum[N-1:0];
            F_SLT:  res_c.y = {{(N-1){1'b0}}, sum[N-1] ^ ovf_raw};
            default: res_c.y = '0;
        endcase
        res_c.cout = arith && sum[N];
        res_c.ovf  = arith && ovf_raw;
        res_c.zero = (res_c.y == '0);
    end

    // Stage 2: result register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2    <= 1'b0;
            res_q <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                res_q <= res_c;
            end
        end
    end

    assign out_valid = v2;
    assign y         = res_q.y;
    assign cout      = res_q.cout;
    assign overflow  = res_q.ovf;
    assign zero      = res_q.zero;

`ifdef PIPE_ALU_STICKY_OVF_EN
    // Set has priority over clear so a retiring overflow is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_ovf <= 1'b0;
        end else if (retire && res_q.ovf) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end
`endif

    a_full_stall: assert property (@(posedge clk) disable iff (reset)
        !in_ready |-> (v1 && v2 && !out_ready));
    a_hold: assert property (@(posedge clk) disable iff (reset)
        (v2 && !out_ready) |=> (v2 && $stable(res_q)));
    a_retire_known: assert property (@(posedge clk) disable iff (reset)
        retire |-> !$isunknown(res_q));

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 The module SHALL have parameter N, default 32, meaning operand/result width in bits (legal 4..64).
REQ-002 The module SHALL have parameter M, default 3, meaning function-select width (fixed at 3; other values unsupported).
REQ-003 The module SHALL have the port clk  input  1  clock; all state updates on the rising edge.
REQ-004 The module SHALL have the port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have the port in_valid  input  1  request carries a valid operation.
REQ-006 The module SHALL have the port in_ready  output  1  the pipeline can accept a request this cycle.
REQ-007 The module SHALL have the ports a  input  N  operand A, b  input  N  operand B, and f  input  M  function select.
REQ-008 The module SHALL have the port out_valid  output  1  result fields hold a valid result.
REQ-009 The module SHALL have the port out_ready  input  1  downstream consumes the result this cycle.
REQ-010 The module SHALL have the ports y  output  N  result, and cout, overflow, zero  output  1 each  flags.

Function
REQ-011 The f encoding SHALL be: 000 a&b, 001 a|b, 010 a+b, 011 reserved, 100 a&~b, 101 a|~b, 110 a-b, 111 SLT.
REQ-012 Arithmetic SHALL be computed as a + bb + f[2], where bb = f[2] ? ~b : b, in N+1 bits.
REQ-013 cout SHALL be bit N of that sum for f in {010,110,111}; for all other f it SHALL be 0.
REQ-014 overflow SHALL be (a[N-1]==bb[N-1]) && (sum[N-1]!=a[N-1]) for f in {010,110,111}; for all other f it SHALL be 0.
REQ-015 For SLT, y SHALL be zero-extended (sum[N-1] XOR overflow), giving a signed less-than.
REQ-016 For f=011, y SHALL be 0, cout and overflow SHALL be 0, and zero SHALL be 1.
REQ-017 zero SHALL be 1 exactly when y is all zeros, for every f.
REQ-018 A request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-019 Pipeline structure: stage 1 registers a, b, f and computes the sum; stage 2 registers y and the flags.
REQ-020 Latency SHALL be 2 cycles: a request accepted at edge k SHALL present out_valid=1 with its result after edge k+1 when stage 2 is free.
REQ-021 A result SHALL leave on an edge where out_valid && out_ready.
REQ-022 Stage 2 SHALL load when it is empty or its result leaves that edge.
REQ-023 in_ready SHALL be !v1 || stage-2-loads, where v1 is stage-1 valid; in_ready SHALL depend combinationally on out_ready.
REQ-024 Throughput SHALL be 1 operation per cycle when out_ready is held 1, with simultaneous accept and retire allowed.
REQ-025 While out_valid=1 and out_ready=0, y and all flags SHALL hold stable, and no result SHALL be dropped or duplicated.
REQ-026 Results SHALL emerge in acceptance order.
REQ-027 With both stages full and out_ready=0, in_ready SHALL be 0.
REQ-028 Operand inputs SHALL be ignored when no request is accepted.

Reset
REQ-029 Asserting reset SHALL asynchronously clear both stage valid bits and set out_valid=0, y=0, cout=0, overflow=0, zero=0.
REQ-030 In-flight operations SHALL be discarded on reset; in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-031 Macro PIPE_ALU_STICKY_OVF_EN SHALL, when defined, add ports sticky_ovf (output, 1 bit) and clr_sticky (input, 1 bit).
REQ-032 With the macro defined, sticky_ovf SHALL set on any edge where a result with overflow=1 retires.
REQ-033 With the macro defined, sticky_ovf SHALL clear on an edge where clr_sticky=1 and no overflow retires; set wins when both occur.
REQ-034 With the macro defined, reset SHALL clear sticky_ovf.
REQ-035 Without the macro, the ports and the sticky register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Test: N=32, f=010, a=7FFFFFFF, b=00000001, out_ready=1 -> 2 cycles later y=80000000, cout=0, overflow=1, zero=0.
REQ-037 Test: f=110, a=00000005, b=00000005 -> y=00000000, cout=1, overflow=0, zero=1; then f=111, a=FFFFFFFF, b=00000001 -> y=00000001.
REQ-038 Test: stream 8 back-to-back requests with out_ready=1 -> 8 in-order results on 8 consecutive cycles, in_ready held at 1.
REQ-039 Test: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after 2 accepts, y stable, then both results retire in order.
REQ-040 Test: assert reset mid-stream with both stages full -> out_valid=0 immediately; no stale result after release.
REQ-041 Test: with PIPE_ALU_STICKY_OVF_EN defined, one overflowing add, then clr_sticky=1 -> sticky_ovf=1 after the retire edge, 0 after the clear edge.
